// File: rtl/rc_filter_seq.sv
// rc_filter_seq: sequencer for the analog RC filter macro.
// A run latches the capacitor-bank selection, holds the discharge switch
// closed for DISCH_CYC cycles, then drives a step into the filter and counts
// cycles until the synchronised comparator trips. The count is reported
// as a time-constant measurement.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   ena          low = synchronous abort to IDLE (result/flags/cap_en kept)
//   start        level request, sampled only in IDLE
//   cap_cfg      capacitor-bank selection, latched on accepted start
//   cmp_in       asynchronous comparator output
//   cap_en       latched capacitor switch enables
//   discharge    discharge switch control
//   step_out     step stimulus into the filter
//   busy         high in DISCHARGE and CHARGE
//   done         one-cycle pulse at the end of a completed run
//   timeout      sticky: last run saturated the counter
//   err          sticky: cap still above threshold after discharge
//   result       last measured cycle count
module rc_filter_seq #(
  parameter int CW          = 16,
  parameter int NCAP        = 4,
  parameter int DISCH_CYC   = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            start,
  input  logic [NCAP-1:0] cap_cfg,
  input  logic            cmp_in,
  output logic [NCAP-1:0] cap_en,
  output logic            discharge,
  output logic            step_out,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic            err,
  output logic [CW-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [CW-1:0] DLAST = CW'(DISCH_CYC - 1);
  localparam logic [CW-1:0] CMAX  = {CW{1'b1}};

  state_t                 state;
  logic [CW-1:0]          dcnt;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cmp_sync;

  // Comparator synchroniser; free-running so abort/restart never sees stale
  // metastable samples beyond the chain depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
  end

  assign cmp_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      cnt       <= '0;
      cap_en    <= '0;
      discharge <= 1'b0;
      step_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
    end else if (!ena) begin
      // Abort: drop all drive to the macro, keep the last results.
      state     <= IDLE;
      discharge <= 1'b0;
      step_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cap_en    <= cap_cfg;
            timeout   <= 1'b0;
            err       <= 1'b0;
            dcnt      <= '0;
            discharge <= 1'b1;
            busy      <= 1'b1;
            state     <= DISCHARGE;
          end
        end
        DISCHARGE: begin
          if (dcnt == DLAST) begin
            discharge <= 1'b0;
            if (cmp_sync) begin
              // Cap never fell below threshold: no point in charging.
              err    <= 1'b1;
              result <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              step_out <= 1'b1;
              cnt      <= '0;
              state    <= CHARGE;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        CHARGE: begin
          // Comparator trip has priority over saturation on the same cycle.
          if (cmp_sync || cnt == CMAX) begin
            result   <= cnt;
            timeout  <= !cmp_sync;
            step_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_filter_seq.sv
module tb_rc_filter_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0, start_b = 1'b0;
  logic [3:0] cap_cfg = '0;
  logic       cmp_in = 1'b0, cmp_b = 1'b0;

  logic [3:0]  cap_en, cap_en_b;
  logic        discharge, step_out, busy, done, timeout, err;
  logic        discharge_b, step_b, busy_b, done_b, timeout_b, err_b;
  logic [15:0] result;
  logic [7:0]  result_b;

  int checks = 0, failures = 0;
  int n_done = 0, n_dis = 0, n_step = 0, n_ovl = 0;
  int n_done_b = 0, n_step_b = 0;

  always #5 clk = ~clk;

  rc_filter_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cap_cfg(cap_cfg),
    .cmp_in(cmp_in), .cap_en(cap_en), .discharge(discharge),
    .step_out(step_out), .busy(busy), .done(done), .timeout(timeout),
    .err(err), .result(result)
  );

  rc_filter_seq #(.CW(8), .DISCH_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .cap_cfg(4'b1001),
    .cmp_in(cmp_b), .cap_en(cap_en_b), .discharge(discharge_b),
    .step_out(step_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .err(err_b), .result(result_b)
  );

  // Cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done)                  n_done++;
    if (discharge)             n_dis++;
    if (step_out)              n_step++;
    if (step_out && discharge) n_ovl++;
    if (done_b)                n_done_b++;
    if (step_b)                n_step_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait: 0=step_out, 1=done, 2=done_b
  task automatic wait_for(input int which, input int limit, input string tag);
    int  i;
    logic hit;
    hit = 1'b0;
    for (i = 0; i < limit && !hit; i++) begin
      tick(1);
      case (which)
        0:       hit = step_out;
        1:       hit = done;
        default: hit = done_b;
      endcase
    end
    chk(tag, hit, 1'b1);
  endtask

  // Standard measurement: cfg 0101, comparator 100 cycles after step -> 102.
  task automatic run_t1(input string tag);
    int d0, dis0;
    d0 = n_done; dis0 = n_dis;
    cap_cfg = 4'b0101; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk({tag, "_cap_en"}, cap_en, 4'b0101);
    chk({tag, "_disch_on"}, discharge, 1'b1);
    wait_for(0, 400, {tag, "_step_wait"});
    chk({tag, "_dis_cycles"}, n_dis - dis0, 255);
    tick(100);
    cmp_in = 1'b1;
    wait_for(1, 50, {tag, "_done_wait"});
    chk({tag, "_result"}, result, 102);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy_done"}, busy, 1'b0);
    tick(1);
    chk({tag, "_done_pulses"}, n_done - d0, 1);
    chk({tag, "_done_low"}, done, 1'b0);
    cmp_in = 1'b0;
    tick(3);
  endtask

  initial begin
    int d0, s0;
    // Reset
    tick(2);
    chk("rst_cap_en", cap_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {discharge, step_out, done, timeout, err}, 0);
    rst_n = 1'b1;
    tick(2);

    // T1
    run_t1("t1");

    // T5: abort mid-CHARGE keeps the previous result, no done pulse
    d0 = n_done;
    start = 1'b1; tick(1); start = 1'b0;
    wait_for(0, 400, "t5_step_wait");
    tick(10);
    ena = 1'b0;
    tick(1);
    ena = 1'b1;
    chk("t5_step_off", step_out, 1'b0);
    chk("t5_busy_off", busy, 1'b0);
    chk("t5_result_kept", result, 102);
    tick(5);
    chk("t5_no_done", n_done - d0, 0);
    chk("t5_still_idle", busy, 1'b0);

    // T4: start during CHARGE ignored, cap_cfg change not latched
    d0 = n_done;
    cap_cfg = 4'b0011; start = 1'b1; tick(1); start = 1'b0;
    cap_cfg = 4'b1111;
    wait_for(0, 400, "t4_step_wait");
    tick(5);
    start = 1'b1; tick(2); start = 1'b0;
    tick(20);
    cmp_in = 1'b1;
    wait_for(1, 50, "t4_done_wait");
    chk("t4_cap_en", cap_en, 4'b0011);
    chk("t4_result", result, 29);
    // Held start: one IDLE cycle, then DISCHARGE. cmp_in stays high (T2).
    s0 = n_step;
    cap_cfg = 4'b0011; start = 1'b1;
    tick(1);
    chk("t4_single_done", n_done - d0, 1);
    chk("t4_idle_gap", {busy, discharge}, 2'b00);
    tick(1);
    chk("t4_retrigger", discharge, 1'b1);
    start = 1'b0;

    // T2: comparator high throughout -> err after discharge
    d0 = n_done;
    wait_for(1, 400, "t2_done_wait");
    chk("t2_err", err, 1'b1);
    chk("t2_result", result, 0);
    chk("t2_timeout", timeout, 1'b0);
    tick(1);
    chk("t2_done_pulses", n_done - d0, 1);
    chk("t2_no_step", n_step - s0, 0);
    cmp_in = 1'b0;
    tick(3);

    // T6: async reset mid-DISCHARGE
    cap_cfg = 4'b0110; start = 1'b1; tick(1); start = 1'b0;
    tick(50);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_cap_en", cap_en, 0);
    chk("t6_disch", discharge, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_result", result, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    run_t1("t6");

    // T3: CW=8, comparator never trips -> saturation
    s0 = n_step_b; d0 = n_done_b;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    wait_for(2, 600, "t3_done_wait");
    chk("t3_result", result_b, 8'hFF);
    chk("t3_timeout", timeout_b, 1'b1);
    chk("t3_err", err_b, 1'b0);
    tick(1);
    chk("t3_charge_cycles", n_step_b - s0, 256);
    chk("t3_done_pulses", n_done_b - d0, 1);
    chk("t3_cap_en", cap_en_b, 4'b1001);

    chk("no_overlap", n_ovl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
